// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage. It owns the program counter, issues one
// instruction-memory request at a time over a valid/ready handshake, and
// loads each returned word into the IF/ID pipeline register. It supports
// back-pressure from ID (stall) and flushes on a taken branch/jump (redirect).
//
// The next PC is chosen by an external 32-bit 2:1 mux. This block drives
// pc_plus4 into mux input 0, the branch/jump target drives input 1, and
// redirect is the mux select. The mux output comes back in as next_pc.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   next_pc         next-PC mux output (low two bits ignored)
//   redirect        taken branch/jump; flushes IF/ID, beats stall
//   stall           ID cannot accept; IF/ID holds
//   pc, pc_plus4    current fetch PC and pc + 4 (combinational)
//   imem_req_*      fetch request handshake (addr = pc)
//   imem_rsp_*      returned instruction word
//   if_id_*         IF/ID register: valid flag, PC and instruction
// ---------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr
);

  // REQ: offering a request. WAIT: one request outstanding.
  // HOLD: a word arrived during a stall and sits in the skid buffer.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;

  logic        load_en;
  logic [31:0] load_pc;
  logic [31:0] load_instr;
  logic [31:0] next_pc_aligned;
  logic        unused_next_pc_lsbs;

  // The PC is word aligned, so the mux output's low bits are dropped.
  assign next_pc_aligned     = {next_pc[31:2], 2'b00};
  assign unused_next_pc_lsbs = ^next_pc[1:0];

  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign imem_req_addr  = pc_q;
  // Reset forces the state to REQ, so the request is masked while rst is high.
  assign imem_req_valid = (state_q == ST_REQ) && !rst;
  assign if_id_valid    = if_id_valid_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_instr    = if_id_instr_q;

  // Next-state logic. A redirect overrides everything else in its cycle:
  // it flushes IF/ID and the skid buffer, and any word already requested
  // for the old path is marked to be dropped when it returns.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    load_en       = 1'b0;
    load_pc       = 32'd0;
    load_instr    = NOP_INSTR;

    if (redirect) begin
      pc_d          = next_pc_aligned;
      if_id_valid_d = 1'b0;
      if_id_pc_d    = 32'd0;
      if_id_instr_d = NOP_INSTR;
      skid_pc_d     = 32'd0;
      skid_instr_d  = NOP_INSTR;
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            state_d = ST_WAIT;
            drop_d  = 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = ST_REQ;
            drop_d  = 1'b0;
          end else begin
            drop_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_REQ;
        end
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            fetch_pc_d = pc_q;
            pc_d       = next_pc_aligned;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            state_d = ST_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (!stall) begin
              load_en    = 1'b1;
              load_pc    = fetch_pc_q;
              load_instr = imem_rsp_data;
            end else begin
              skid_pc_d    = fetch_pc_q;
              skid_instr_d = imem_rsp_data;
              state_d      = ST_HOLD;
            end
          end
        end
        default: begin
          if (!stall) begin
            load_en    = 1'b1;
            load_pc    = skid_pc_q;
            load_instr = skid_instr_q;
            state_d    = ST_REQ;
          end
        end
      endcase

      // Without a stall, IF/ID either takes a new word or drains to a bubble
      // (PC field kept). With a stall it simply holds.
      if (load_en) begin
        if_id_valid_d = 1'b1;
        if_id_pc_d    = load_pc;
        if_id_instr_d = load_instr;
      end else if (!stall) begin
        if_id_valid_d = 1'b0;
        if_id_instr_d = NOP_INSTR;
      end
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      fetch_pc_q    <= 32'd0;
      drop_q        <= 1'b0;
      skid_pc_q     <= 32'd0;
      skid_instr_q  <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= 32'd0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      drop_q        <= drop_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_stage
//
// Self-checking bench for if_fetch_stage. A transaction-level model tracks
// the fetch PC, whether a request is outstanding (and whether its word must
// be dropped), a word parked behind a stall, and the expected IF/ID contents.
// Directed scenarios come first, then a randomized run with a small memory
// responder that answers each accepted request after a random delay.
// ---------------------------------------------------------------------------
module tb_if_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_busy;
  logic        m_drop;
  logic [31:0] m_fetch_pc;
  logic        m_held;
  logic [31:0] m_held_pc;
  logic [31:0] m_held_instr;
  logic        m_v;
  logic [31:0] m_ipc;
  logic [31:0] m_instr;

  if_fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .next_pc        (next_pc),
    .redirect       (redirect),
    .stall          (stall),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_id_valid    (if_id_valid),
    .if_id_pc       (if_id_pc),
    .if_id_instr    (if_id_instr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RESET_PC; m_busy = 1'b0; m_drop = 1'b0; m_fetch_pc = 32'd0;
    m_held = 1'b0; m_held_pc = 32'd0; m_held_instr = NOP;
    m_v = 1'b0; m_ipc = 32'd0; m_instr = NOP;
  endtask

  // Drives one clock cycle of inputs and advances the model by the same
  // cycle. The external mux picks target on redirect, else pc + 4.
  task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic redir, input logic [31:0] tgt);
    logic [31:0] npc, n_pc, n_fetch, n_hpc, n_hinstr, n_ipc, n_instr;
    logic        n_busy, n_drop, n_held, n_v, loaded, offering;
    npc = redir ? tgt : m_pc + 32'd4;
    imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = rd;
    stall = st; redirect = redir; next_pc = npc;
    n_pc = m_pc; n_fetch = m_fetch_pc; n_hpc = m_held_pc; n_hinstr = m_held_instr;
    n_busy = m_busy; n_drop = m_drop; n_held = m_held;
    n_v = m_v; n_ipc = m_ipc; n_instr = m_instr;
    offering = !m_busy && !m_held;
    loaded = 1'b0;
    if (redir) begin
      n_pc = {npc[31:2], 2'b00};
      n_v = 1'b0; n_ipc = 32'd0; n_instr = NOP; n_held = 1'b0;
      if (offering) begin
        if (rdy) begin n_busy = 1'b1; n_drop = 1'b1; end
      end else if (m_busy) begin
        if (rv) begin n_busy = 1'b0; n_drop = 1'b0; end
        else n_drop = 1'b1;
      end
    end else begin
      if (offering && rdy) begin
        n_fetch = m_pc; n_pc = {npc[31:2], 2'b00}; n_busy = 1'b1;
      end else if (m_busy && rv) begin
        n_busy = 1'b0;
        if (m_drop) n_drop = 1'b0;
        else if (!st) begin n_v = 1'b1; n_ipc = m_fetch_pc; n_instr = rd; loaded = 1'b1; end
        else begin n_held = 1'b1; n_hpc = m_fetch_pc; n_hinstr = rd; end
      end else if (m_held && !st) begin
        n_held = 1'b0; n_v = 1'b1; n_ipc = m_held_pc; n_instr = m_held_instr; loaded = 1'b1;
      end
      if (!st && !loaded) begin n_v = 1'b0; n_instr = NOP; end
    end
    @(posedge clk);
    m_pc = n_pc; m_fetch_pc = n_fetch; m_held_pc = n_hpc; m_held_instr = n_hinstr;
    m_busy = n_busy; m_drop = n_drop; m_held = n_held;
    m_v = n_v; m_ipc = n_ipc; m_instr = n_instr;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; next_pc = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; next_pc = 32'd0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    n_compared++; if (pc !== RESET_PC) begin n_mismatched++; $display("[TB] FAIL reset_pc: got %h want %h", pc, RESET_PC); end
    n_compared++; if (pc_plus4 !== 32'd4) begin n_mismatched++; $display("[TB] FAIL reset_pc_plus4: got %h want %h", pc_plus4, 32'd4); end
    n_compared++; if (imem_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_compared++; if (if_id_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_if_id_valid: got %b want 0", if_id_valid); end
    n_compared++; if (if_id_pc !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_if_id_pc: got %h want 0", if_id_pc); end
    n_compared++; if (if_id_instr !== NOP) begin n_mismatched++; $display("[TB] FAIL reset_if_id_instr: got %h want %h", if_id_instr, NOP); end
    rst = 1'b0; imem_req_ready = 1'b0;
    model_reset();
    #1;
    n_compared++; if (imem_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL post_reset_req_valid: got %b want 1", imem_req_valid); end
  endtask

  task automatic test_first_fetch();
    do_reset();
    n_compared++; if (imem_req_addr !== 32'd0) begin n_mismatched++; $display("[TB] FAIL first_addr: got %h want 0", imem_req_addr); end
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_compared++; if (pc !== 32'd4) begin n_mismatched++; $display("[TB] FAIL first_pc: got %h want 4", pc); end
    n_compared++; if (imem_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL first_wait_req: got %b want 0", imem_req_valid); end
    cycle(1'b0, 1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'd0);
    n_compared++; if (if_id_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL first_valid: got %b want 1", if_id_valid); end
    n_compared++; if (if_id_pc !== 32'd0) begin n_mismatched++; $display("[TB] FAIL first_if_id_pc: got %h want 0", if_id_pc); end
    n_compared++; if (if_id_instr !== 32'h0050_0093) begin n_mismatched++; $display("[TB] FAIL first_instr: got %h want 00500093", if_id_instr); end
  endtask

  task automatic test_straight_line();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
      n_compared++; if (if_id_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL line_bubble[%0d]: got %b want 0", i, if_id_valid); end
      cycle(1'b0, 1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
      n_compared++; if (if_id_pc !== 32'(i * 4)) begin n_mismatched++; $display("[TB] FAIL line_pc[%0d]: got %h want %h", i, if_id_pc, 32'(i * 4)); end
      n_compared++; if (if_id_instr !== 32'hA000_0000 + 32'(i)) begin n_mismatched++; $display("[TB] FAIL line_instr[%0d]: got %h want %h", i, if_id_instr, 32'hA000_0000 + 32'(i)); end
      n_compared++; if (if_id_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL line_valid[%0d]: got %b want 1", i, if_id_valid); end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'hB000_0000, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'hB000_0004, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    n_compared++; if (if_id_pc !== 32'd4) begin n_mismatched++; $display("[TB] FAIL stall_hold_pc_a: got %h want 4", if_id_pc); end
    cycle(1'b0, 1'b1, 32'hB000_0008, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      n_compared++; if (imem_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stall_no_req[%0d]: got %b want 0", i, imem_req_valid); end
      n_compared++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'd4, 32'hB000_0004}) begin n_mismatched++; $display("[TB] FAIL stall_hold_ifid[%0d]: got %b/%h/%h want 1/4/b0000004", i, if_id_valid, if_id_pc, if_id_instr); end
      cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    end
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_compared++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'd8, 32'hB000_0008}) begin n_mismatched++; $display("[TB] FAIL stall_release_ifid: got %b/%h/%h want 1/8/b0000008", if_id_valid, if_id_pc, if_id_instr); end
    n_compared++; if (pc !== 32'hC) begin n_mismatched++; $display("[TB] FAIL stall_release_pc: got %h want c", pc); end
  endtask

  // Continues from test_stall_hold: REQ with pc = 0xC.
  task automatic test_redirect_wait();
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_compared++; if (if_id_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL redir_drain: got %b want 0", if_id_valid); end
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0100);
    n_compared++; if (pc !== 32'h100) begin n_mismatched++; $display("[TB] FAIL redir_pc: got %h want 100", pc); end
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    n_compared++; if (if_id_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL redir_discard: got %b want 0", if_id_valid); end
    n_compared++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h100}) begin n_mismatched++; $display("[TB] FAIL redir_req: got %b/%h want 1/100", imem_req_valid, imem_req_addr); end
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b1, 32'hC000_0100, 1'b0, 1'b0, 32'd0);
    n_compared++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b1, 32'h100, 32'hC000_0100}) begin n_mismatched++; $display("[TB] FAIL redir_target_ifid: got %b/%h/%h want 1/100/c0000100", if_id_valid, if_id_pc, if_id_instr); end
  endtask

  // Continues with a valid instruction in IF/ID.
  task automatic test_redirect_stall();
    cycle(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_2000);
    n_compared++; if ({if_id_valid, if_id_pc, if_id_instr} !== {1'b0, 32'd0, NOP}) begin n_mismatched++; $display("[TB] FAIL flush_over_stall: got %b/%h/%h want 0/0/%h", if_id_valid, if_id_pc, if_id_instr, NOP); end
    n_compared++; if (pc !== 32'h2000) begin n_mismatched++; $display("[TB] FAIL flush_pc: got %h want 2000", pc); end
  endtask

  task automatic test_wrap_and_reset();
    cycle(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    n_compared++; if (pc !== 32'hFFFF_FFFC) begin n_mismatched++; $display("[TB] FAIL align_pc: got %h want fffffffc", pc); end
    n_compared++; if (pc_plus4 !== 32'd0) begin n_mismatched++; $display("[TB] FAIL wrap_plus4: got %h want 0", pc_plus4); end
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_compared++; if (pc !== 32'd0) begin n_mismatched++; $display("[TB] FAIL wrap_pc: got %h want 0", pc); end
    cycle(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
    n_compared++; if (if_id_pc !== 32'hFFFF_FFFC) begin n_mismatched++; $display("[TB] FAIL wrap_if_id_pc: got %h want fffffffc", if_id_pc); end
    cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    n_compared++; if (pc !== 32'd4) begin n_mismatched++; $display("[TB] FAIL pre_reset_pc: got %h want 4", pc); end
    #3 rst = 1'b1;
    #1;
    n_compared++; if (pc !== RESET_PC) begin n_mismatched++; $display("[TB] FAIL async_reset_pc: got %h want %h", pc, RESET_PC); end
    n_compared++; if (imem_req_valid !== 1'b0) begin n_mismatched++; $display("[TB] FAIL async_reset_req: got %b want 0", imem_req_valid); end
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    cycle(1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'd0);
    n_compared++; if ({if_id_valid, if_id_instr} !== {1'b0, NOP}) begin n_mismatched++; $display("[TB] FAIL late_rsp_ignored: got %b/%h want 0/%h", if_id_valid, if_id_instr, NOP); end
    n_compared++; if (imem_req_valid !== 1'b1) begin n_mismatched++; $display("[TB] FAIL late_rsp_state: got %b want 1", imem_req_valid); end
  endtask

  task automatic test_random();
    logic        mem_pending;
    int          mem_cnt;
    logic        rdy, rv, st, redir, accepted;
    logic [31:0] rd, tgt;
    do_reset();
    mem_pending = 1'b0; mem_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      n_compared++; if (pc !== m_pc) begin n_mismatched++; $display("[TB] FAIL rand_pc[%0d]: got %h want %h", i, pc, m_pc); end
      n_compared++; if (pc_plus4 !== m_pc + 32'd4) begin n_mismatched++; $display("[TB] FAIL rand_pc_plus4[%0d]: got %h want %h", i, pc_plus4, m_pc + 32'd4); end
      n_compared++; if (imem_req_valid !== (!m_busy && !m_held)) begin n_mismatched++; $display("[TB] FAIL rand_req_valid[%0d]: got %b want %b", i, imem_req_valid, !m_busy && !m_held); end
      n_compared++; if (imem_req_addr !== m_pc) begin n_mismatched++; $display("[TB] FAIL rand_req_addr[%0d]: got %h want %h", i, imem_req_addr, m_pc); end
      n_compared++; if (if_id_valid !== m_v) begin n_mismatched++; $display("[TB] FAIL rand_if_id_valid[%0d]: got %b want %b", i, if_id_valid, m_v); end
      n_compared++; if (if_id_pc !== m_ipc) begin n_mismatched++; $display("[TB] FAIL rand_if_id_pc[%0d]: got %h want %h", i, if_id_pc, m_ipc); end
      n_compared++; if (if_id_instr !== m_instr) begin n_mismatched++; $display("[TB] FAIL rand_if_id_instr[%0d]: got %h want %h", i, if_id_instr, m_instr); end
      rdy   = ($urandom_range(0, 3) != 0);
      st    = ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 9) == 0);
      tgt   = $urandom;
      rd    = $urandom;
      rv    = 1'b0;
      if (mem_pending) begin
        if (mem_cnt == 0) begin rv = 1'b1; mem_pending = 1'b0; end
        else mem_cnt--;
      end else if (!m_busy) begin
        rv = ($urandom_range(0, 7) == 0);
      end
      accepted = !m_busy && !m_held && rdy;
      cycle(rdy, rv, rd, st, redir, tgt);
      if (accepted) begin
        mem_pending = 1'b1;
        mem_cnt = $urandom_range(0, 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_straight_line();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
